// File: rtl/touch_led_ctrl.sv
// ---------------------------------------------------------------------------
// touch_led_ctrl
//   Toggles an LED on every debounced press of a capacitive touch key.
//   The raw key level is synchronised (two flops), debounced (a level change
//   is accepted only after DEBOUNCE_CYCLES consecutive stable samples), and
//   rising-edge detected. Each accepted press inverts the LED and emits a
//   one-cycle strobe.
//
//   Optional feature (macro TOUCH_LONG_PRESS_EN): a hold counter runs while
//   the debounced key is held. Once it reaches LONG_PRESS_CYCLES-1 the LED is
//   forced off on the next edge, without a press_pulse strobe.
//
// Ports:
//   sys_clk     in   system clock, rising-edge active
//   sys_rst     in   asynchronous, active-high reset
//   touch       in   raw touch-key level (1 = touched), asynchronous
//   led         out  registered LED drive (1 = on)
//   press_pulse out  one-cycle strobe in the cycle led toggles
// ---------------------------------------------------------------------------
module touch_led_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES   = 16,
   parameter int unsigned CNT_W             = 20,
   parameter logic        LED_RESET_VAL     = 1'b0,
   parameter int unsigned LONG_PRESS_CYCLES = 1000
) (
   input  logic sys_clk,
   input  logic sys_rst,
   input  logic touch,
   output logic led,
   output logic press_pulse
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Elaboration-time parameter sanity checks.
   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 20)) begin : g_chk_db_range
      $error("touch_led_ctrl: DEBOUNCE_CYCLES out of range 1..2^20");
   end
   if (CNT_W < 32 && ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_chk_cnt_w
      $error("touch_led_ctrl: CNT_W too narrow for DEBOUNCE_CYCLES");
   end
   if (LONG_PRESS_CYCLES < 1) begin : g_chk_long
      $error("touch_led_ctrl: LONG_PRESS_CYCLES must be at least 1");
   end

   logic             s1;
   logic             s2;
   logic             db;
   logic [CNT_W-1:0] cnt;

`ifdef TOUCH_LONG_PRESS_EN
   localparam int unsigned     HOLD_W    = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_PRESS_CYCLES - 1);
   logic [HOLD_W-1:0] hold;
`endif

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         db          <= 1'b0;
         cnt         <= '0;
         led         <= LED_RESET_VAL;
         press_pulse <= 1'b0;
`ifdef TOUCH_LONG_PRESS_EN
         hold        <= '0;
`endif
      end else begin
         s1          <= touch;
         s2          <= s1;
         press_pulse <= 1'b0;

         // The toggle is decided on the same edge that accepts the new
         // debounced level, so led and db change together.
         if (s2 == db) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            db  <= s2;
            cnt <= '0;
            if (s2) begin
               led         <= ~led;
               press_pulse <= 1'b1;
            end
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

`ifdef TOUCH_LONG_PRESS_EN
         // Toggling only happens while db==0, so this later assignment never
         // collides with a toggle on the same edge.
         if (db) begin
            if (hold != HOLD_MAX) begin
               hold <= hold + HOLD_W'(1);
            end
            if (hold == HOLD_FIRE) begin
               led <= 1'b0;
            end
         end else begin
            hold <= '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_touch_led_ctrl.sv
// ---------------------------------------------------------------------------
// tb_touch_led_ctrl
//   Self-checking bench for touch_led_ctrl (default build, default
//   parameters). The reference model keeps a window of recent touch samples:
//   the debounced level flips on an edge when every sample seen by the
//   debouncer over the last DEBOUNCE_CYCLES edges differs from the current
//   level. Directed scenarios come first, then randomised hold/release runs
//   with occasional resets.
// ---------------------------------------------------------------------------
module tb_touch_led_ctrl;

   localparam int unsigned DB = 16;

   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   logic touch   = 1'b0;
   logic led;
   logic press_pulse;

   touch_led_ctrl #(
      .DEBOUNCE_CYCLES   (DB),
      .CNT_W             (20),
      .LED_RESET_VAL     (1'b0),
      .LONG_PRESS_CYCLES (1000)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .touch       (touch),
      .led         (led),
      .press_pulse (press_pulse)
   );

   always #5 sys_clk = ~sys_clk;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;
   int unsigned dut_pulses = 0;

   // hist[k] = touch value sampled k edges ago (hist[0] = this edge).
   logic [DB+1:0] hist;
   logic          m_db;
   logic          m_led;
   logic          m_pulse;

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
   endtask

   task automatic check_int(input string tag, input int unsigned obs, input int unsigned exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_reset();
      hist    = '0;
      m_db    = 1'b0;
      m_led   = 1'b0;
      m_pulse = 1'b0;
   endtask

   // The debouncer on edge e sees the touch value sampled two edges earlier,
   // so the relevant window is hist[DB+1:2].
   task automatic model_edge(input logic t);
      logic flip;
      hist    = {hist[DB:0], t};
      flip    = m_db ? (hist[DB+1:2] == '0) : (hist[DB+1:2] == '1);
      m_pulse = 1'b0;
      if (flip) begin
         m_db = ~m_db;
         if (m_db) begin
            m_led   = ~m_led;
            m_pulse = 1'b1;
         end
      end
   endtask

   // One clock: drive touch (called at a falling edge), advance the model on
   // the rising edge, compare on the next falling edge.
   task automatic cycle(input logic t);
      touch = t;
      @(posedge sys_clk);
      if (sys_rst) model_reset();
      else         model_edge(t);
      @(negedge sys_clk);
      check_bit("led", led, m_led);
      check_bit("press_pulse", press_pulse, m_pulse);
      if (press_pulse) dut_pulses++;
   endtask

   initial begin
      model_reset();
      sys_rst = 1'b1;
      @(negedge sys_clk);

      // Reset held with touch toggling.
      for (int i = 0; i < 50; i++) cycle(logic'(i % 2));
      check_bit("reset_led", led, 1'b0);
      check_int("reset_pulses", dut_pulses, 0);

      // Single press.
      sys_rst = 1'b0;
      repeat (DB + 1) cycle(1'b1);
      check_bit("single_before_edge17", led, 1'b0);
      cycle(1'b1);
      check_bit("single_at_edge17_led", led, 1'b1);
      check_bit("single_at_edge17_pulse", press_pulse, 1'b1);
      repeat (100 - DB - 2) cycle(1'b1);
      repeat (100) cycle(1'b0);
      check_bit("single_after_release", led, 1'b1);
      check_int("single_pulses", dut_pulses, 1);

      // Second press toggles back.
      repeat (100) cycle(1'b1);
      repeat (100) cycle(1'b0);
      check_bit("two_press_led", led, 1'b0);
      check_int("two_press_pulses", dut_pulses, 2);

      // Glitch shorter than the debounce window.
      repeat (10) cycle(1'b1);
      repeat (40) cycle(1'b0);
      check_bit("glitch_led", led, 1'b0);
      check_int("glitch_pulses", dut_pulses, 2);

      // Bouncy press: toggles every 3 cycles, then a stable hold.
      for (int i = 0; i < 30; i++) cycle(logic'(((i / 3) % 2) == 0));
      repeat (50) cycle(1'b1);
      repeat (50) cycle(1'b0);
      check_bit("bouncy_led", led, 1'b1);
      check_int("bouncy_pulses", dut_pulses, 3);

      // Reset during a hold; the still-held key counts as a new press.
      repeat (30) cycle(1'b1);
      sys_rst = 1'b1;
      repeat (5) cycle(1'b1);
      check_bit("rst_hold_in_reset", led, 1'b0);
      sys_rst = 1'b0;
      repeat (DB + 1) cycle(1'b1);
      check_bit("rst_hold_before_toggle", led, 1'b0);
      cycle(1'b1);
      check_bit("rst_hold_toggle_led", led, 1'b1);
      check_bit("rst_hold_toggle_pulse", press_pulse, 1'b1);
      repeat (40) cycle(1'b1);
      repeat (40) cycle(1'b0);

      // Randomised runs of random length, with occasional short resets.
      for (int s = 0; s < 80; s++) begin
         logic        lvl;
         int unsigned len;
         lvl = logic'($urandom_range(1, 0));
         len = $urandom_range(40, 1);
         if ($urandom_range(19, 0) == 0) begin
            sys_rst = 1'b1;
            repeat ($urandom_range(3, 1)) cycle(lvl);
            sys_rst = 1'b0;
         end
         repeat (len) cycle(lvl);
      end
      repeat (DB + 4) cycle(1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
